// File: rtl/micro_port_tx.sv
// Byte transmitter for the display FPGA micro port: 4-entry FIFO feeding a
// SETUP/STROBE/HOLD write-strobe sequencer with idle bus values of 8'hFF / 1.
module micro_port_tx #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rsel,
  output logic [7:0] port_out,
  output logic       rsel_out,
  output logic       write_n,
  output logic       busy,
  output logic       byte_done,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC);
  localparam logic [3:0] STROBE_L = 4'(STROBE_CYC);
  localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC);

  logic [8:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic [8:0] head;
  logic       push, pop, fifo_nonempty;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] port_q;
  logic       rsel_q, wn_q, busy_q, done_q;

  assign in_ready      = !Reset && (count_q < 3'd4);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (count_q != 3'd0);
  assign head          = mem_q[rd_ptr_q];

  // Pops happen in IDLE, or on HOLD expiry so the next byte skips IDLE entirely.
  assign pop = fifo_nonempty &&
               ((state_q == IDLE) || ((state_q == HOLD) && (cnt_q == 4'd1)));

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_rsel, in_data};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= '1;
      rsel_q  <= 1'b1;
      wn_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_nonempty) begin
            port_q  <= head[7:0];
            rsel_q  <= head[8];
            cnt_q   <= SETUP_L;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd1) begin
            wn_q    <= 1'b0;
            cnt_q   <= STROBE_L;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd1) begin
            wn_q    <= 1'b1;
            done_q  <= 1'b1;
            cnt_q   <= HOLD_L;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd1) begin
            if (fifo_nonempty) begin
              port_q  <= head[7:0];
              rsel_q  <= head[8];
              cnt_q   <= SETUP_L;
              state_q <= SETUP;
            end else begin
              port_q  <= '1;
              rsel_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign port_out   = port_q;
  assign rsel_out   = rsel_q;
  assign write_n    = wn_q;
  assign busy       = busy_q;
  assign byte_done  = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_micro_port_tx.sv
// Directed testbench for micro_port_tx: default timing instance plus a 1/1/1 timing instance.
module tb_micro_port_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v0 = 1'b0, rs0 = 1'b0;
  logic [7:0] d0 = '0;
  logic       rdy0, rsel0, wn0, busy0, done0;
  logic [7:0] port0;
  logic [2:0] cnt0;

  logic       v1 = 1'b0, rs1 = 1'b0;
  logic [7:0] d1 = '0;
  logic       rdy1, rsel1, wn1, busy1, done1;
  logic [7:0] port1;
  logic [2:0] cnt1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int         cyc = 0;
  int         done_pulses = 0;
  int         viol = 0;
  logic       wn_prev = 1'b1;
  logic [7:0] port_prev = 8'hFF;
  logic [7:0] log_d [$];
  logic       log_r [$];
  int         log_c [$];

  micro_port_tx dut0 (
    .Clk(clk), .Reset(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_rsel(rs0),
    .port_out(port0), .rsel_out(rsel0), .write_n(wn0), .busy(busy0), .byte_done(done0),
    .fifo_count(cnt0)
  );

  micro_port_tx #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut1 (
    .Clk(clk), .Reset(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_rsel(rs1),
    .port_out(port1), .rsel_out(rsel1), .write_n(wn1), .busy(busy1), .byte_done(done1),
    .fifo_count(cnt1)
  );

  always #5 clk = ~clk;

  // Records every falling strobe on dut0 and any bus change while the strobe is low.
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (wn_prev && !wn0) begin
      log_d.push_back(port0);
      log_r.push_back(rsel0);
      log_c.push_back(cyc + 1);
    end
    if (!wn_prev && !wn0 && (port0 !== port_prev)) viol <= viol + 1;
    if (done0) done_pulses <= done_pulses + 1;
    wn_prev   <= wn0;
    port_prev <= port0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_r.delete();
    log_c.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!((busy0 === 1'b0) && (cnt0 === 3'd0)) && (n < budget)) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%b count=%0d after %0d cycles, required idle", busy0, cnt0, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1; d0 = 8'h99; rs0 = 1'b0;
    tick(); tick();
    n_cmp++; if (wn0 !== 1'b1)    begin n_bad++; $display("FAIL reset_wn: got %b want 1", wn0); end
    n_cmp++; if (port0 !== 8'hFF) begin n_bad++; $display("FAIL reset_port: got %h want ff", port0); end
    n_cmp++; if (rsel0 !== 1'b1)  begin n_bad++; $display("FAIL reset_rsel: got %b want 1", rsel0); end
    n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done0); end
    n_cmp++; if (cnt0 !== 3'd0)   begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    n_cmp++; if (rdy0 !== 1'b0)   begin n_bad++; $display("FAIL reset_ready: got %b want 0", rdy0); end
    v0 = 1'b0;
  endtask

  task automatic test_single();
    logic       exp_wn   [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic       exp_done [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       exp_busy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0] exp_port [9] = '{8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'hFF};
    clear_log();
    rst = 1'b0; v0 = 1'b1; d0 = 8'h12; rs0 = 1'b1;
    tick();
    v0 = 1'b0;
    n_cmp++; if (cnt0 !== 3'd1) begin n_bad++; $display("FAIL single_first_accept: count got %0d want 1", cnt0); end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if (wn0 !== exp_wn[i]) begin n_bad++; $display("FAIL single_wn t+%0d: got %b want %b", i + 1, wn0, exp_wn[i]); end
      n_cmp++; if (done0 !== exp_done[i]) begin n_bad++; $display("FAIL single_done t+%0d: got %b want %b", i + 1, done0, exp_done[i]); end
      n_cmp++; if (busy0 !== exp_busy[i]) begin n_bad++; $display("FAIL single_busy t+%0d: got %b want %b", i + 1, busy0, exp_busy[i]); end
      n_cmp++; if (port0 !== exp_port[i]) begin n_bad++; $display("FAIL single_port t+%0d: got %h want %h", i + 1, port0, exp_port[i]); end
      n_cmp++; if (rsel0 !== 1'b1) begin n_bad++; $display("FAIL single_rsel t+%0d: got %b want 1", i + 1, rsel0); end
    end
  endtask

  task automatic test_burst();
    logic [7:0] bd [4] = '{8'h01, 8'hA0, 8'hA1, 8'hA2};
    logic       br [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    clear_log();
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; d0 = bd[i]; rs0 = br[i];
      tick();
      n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL burst_ready beat %0d: got %b want 1", i, rdy0); end
    end
    v0 = 1'b0;
    n_cmp++; if (cnt0 !== 3'd3) begin n_bad++; $display("FAIL burst_count: got %0d want 3", cnt0); end
    for (int i = 4; i <= 32; i++) begin
      tick();
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL burst_busy t+%0d: got %b want 1", i, busy0); end
    end
    tick();
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL burst_busy_end: got %b want 0", busy0); end
    n_cmp++;
    if (log_d.size() != 4) begin
      n_bad++; $display("FAIL burst_nbytes: got %0d want 4", log_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (log_d[i] !== bd[i]) begin n_bad++; $display("FAIL burst_data %0d: got %h want %h", i, log_d[i], bd[i]); end
        n_cmp++; if (log_r[i] !== br[i]) begin n_bad++; $display("FAIL burst_rsel %0d: got %b want %b", i, log_r[i], br[i]); end
        if (i > 0) begin
          n_cmp++; if (log_c[i] - log_c[i-1] != 8) begin n_bad++; $display("FAIL burst_spacing %0d: got %0d want 8", i, log_c[i] - log_c[i-1]); end
        end
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] fd [6] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    logic [2:0] exp_cnt [11] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 3, 4};
    logic       exp_rdy [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    int k;
    logic acc;
    clear_log();
    k = 0;
    for (int i = 0; i < 11; i++) begin
      v0 = (k < 6); d0 = fd[k < 6 ? k : 0]; rs0 = k[0];
      acc = v0 && rdy0;
      tick();
      if (acc) k++;
      n_cmp++; if (cnt0 !== exp_cnt[i]) begin n_bad++; $display("FAIL full_count t+%0d: got %0d want %0d", i, cnt0, exp_cnt[i]); end
      n_cmp++; if (rdy0 !== exp_rdy[i]) begin n_bad++; $display("FAIL full_ready t+%0d: got %b want %b", i, rdy0, exp_rdy[i]); end
    end
    v0 = 1'b0;
    n_cmp++; if (k != 6) begin n_bad++; $display("FAIL full_accepted: got %0d want 6", k); end
    wait_idle(120);
    n_cmp++;
    if (log_d.size() != 6) begin
      n_bad++; $display("FAIL full_nbytes: got %0d want 6", log_d.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (log_d[i] !== fd[i]) begin n_bad++; $display("FAIL full_order %0d: got %h want %h", i, log_d[i], fd[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses0;
    clear_log();
    pulses0 = done_pulses;
    v0 = 1'b1; rs0 = 1'b0;
    d0 = 8'h55; tick();
    d0 = 8'h66; tick();
    d0 = 8'h77; tick();
    v0 = 1'b0;
    tick();
    n_cmp++; if (wn0 !== 1'b0) begin n_bad++; $display("FAIL rmid_strobe1: got %b want 0", wn0); end
    tick();
    n_cmp++; if (wn0 !== 1'b0) begin n_bad++; $display("FAIL rmid_strobe2: got %b want 0", wn0); end
    n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL rmid_queued: got %0d want 2", cnt0); end
    rst = 1'b1;
    tick();
    n_cmp++; if (wn0 !== 1'b1)    begin n_bad++; $display("FAIL rmid_wn: got %b want 1", wn0); end
    n_cmp++; if (port0 !== 8'hFF) begin n_bad++; $display("FAIL rmid_port: got %h want ff", port0); end
    n_cmp++; if (rsel0 !== 1'b1)  begin n_bad++; $display("FAIL rmid_rsel: got %b want 1", rsel0); end
    n_cmp++; if (cnt0 !== 3'd0)   begin n_bad++; $display("FAIL rmid_count: got %0d want 0", cnt0); end
    n_cmp++; if (rdy0 !== 1'b0)   begin n_bad++; $display("FAIL rmid_ready: got %b want 0", rdy0); end
    n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy0); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (done_pulses != pulses0) begin n_bad++; $display("FAIL rmid_done: got %0d pulses want 0", done_pulses - pulses0); end
    n_cmp++; if (log_d.size() != 1) begin n_bad++; $display("FAIL rmid_nbytes: got %0d strobes want 1", log_d.size()); end
    n_cmp++; if (wn0 !== 1'b1 || port0 !== 8'hFF) begin n_bad++; $display("FAIL rmid_after: wn=%b port=%h want 1/ff", wn0, port0); end
  endtask

  task automatic test_push_pop();
    logic [7:0] pd [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    clear_log();
    v0 = 1'b1; rs0 = 1'b0;
    d0 = pd[0]; tick();
    d0 = pd[1]; tick();
    d0 = pd[2]; tick();
    v0 = 1'b0;
    n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL pp_pre_count: got %0d want 2", cnt0); end
    for (int i = 3; i <= 8; i++) tick();
    v0 = 1'b1; d0 = pd[3];
    tick();
    v0 = 1'b0;
    n_cmp++; if (cnt0 !== 3'd2)   begin n_bad++; $display("FAIL pp_count: got %0d want 2", cnt0); end
    n_cmp++; if (port0 !== pd[1]) begin n_bad++; $display("FAIL pp_next: got %h want %h", port0, pd[1]); end
    n_cmp++; if (busy0 !== 1'b1)  begin n_bad++; $display("FAIL pp_busy: got %b want 1", busy0); end
    wait_idle(80);
    n_cmp++;
    if (log_d.size() != 4) begin
      n_bad++; $display("FAIL pp_nbytes: got %0d want 4", log_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (log_d[i] !== pd[i]) begin n_bad++; $display("FAIL pp_order %0d: got %h want %h", i, log_d[i], pd[i]); end
      end
    end
  endtask

  task automatic test_fast();
    logic [7:0] fb [3] = '{8'hF1, 8'hF2, 8'hF3};
    logic       fr [3] = '{1'b1, 1'b0, 1'b1};
    logic       exp_wn   [10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    logic       exp_rsel [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic [7:0] exp_port [10] = '{8'hF1, 8'hF1, 8'hF1, 8'hF2, 8'hF2, 8'hF2,
                                  8'hF3, 8'hF3, 8'hF3, 8'hFF};
    for (int i = 0; i <= 10; i++) begin
      v1 = (i < 3); d1 = fb[i < 3 ? i : 0]; rs1 = fr[i < 3 ? i : 0];
      tick();
      if (i >= 1) begin
        n_cmp++; if (wn1 !== exp_wn[i-1]) begin n_bad++; $display("FAIL fast_wn t+%0d: got %b want %b", i, wn1, exp_wn[i-1]); end
        n_cmp++; if (port1 !== exp_port[i-1]) begin n_bad++; $display("FAIL fast_port t+%0d: got %h want %h", i, port1, exp_port[i-1]); end
        n_cmp++; if (rsel1 !== exp_rsel[i-1]) begin n_bad++; $display("FAIL fast_rsel t+%0d: got %b want %b", i, rsel1, exp_rsel[i-1]); end
      end
    end
    v1 = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL fast_idle: busy got %b want 0", busy1); end
  endtask

  task automatic test_bus_stable();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bus_stable: got %0d changes while strobe low want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_reset_mid();
    test_push_pop();
    test_fast();
    test_bus_stable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/micro_port_tx.md
MICRO_PORT_TX -- requirements
Module: micro_port_tx

Interface
- REQ-001: Parameter SETUP_CYC, default 2, cycles port_out/rsel_out are stable before write_n falls (legal range 1..15).
- REQ-002: Parameter STROBE_CYC, default 4, cycles write_n is held low (legal range 1..15).
- REQ-003: Parameter HOLD_CYC, default 2, cycles port_out/rsel_out are held after write_n rises (legal range 1..15).
- REQ-004: Clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: Reset  input  1  synchronous, active-high reset.
- REQ-006: in_valid  input  1  upstream beat valid.
- REQ-007: in_ready  output  1  block can accept a beat; equals (fifo_count < 4).
- REQ-008: in_data  input  8  byte to transmit.
- REQ-009: in_rsel  input  1  1 = register-select byte, 0 = data byte.
- REQ-010: port_out  output  8  parallel bus to the display FPGA micro port; idle value 8'hFF.
- REQ-011: rsel_out  output  1  register-select line; idle value 1.
- REQ-012: write_n  output  1  active-low write strobe; idle value 1.
- REQ-013: busy  output  1  high whenever the FSM is not IDLE.
- REQ-014: byte_done  output  1  one-cycle pulse in the cycle write_n returns high.
- REQ-015: fifo_count  output  3  current FIFO occupancy, 0..4.

Function
- REQ-016: A beat is accepted on a rising edge where in_valid and in_ready are both high; {in_rsel, in_data} is pushed into a 4-entry FIFO.
- REQ-017: FSM states: IDLE, SETUP, STROBE, HOLD; a single down-counter times each state.
- REQ-018: IDLE with FIFO non-empty: pop the head entry, load port_out/rsel_out from it, and go to SETUP with the counter set to SETUP_CYC.
- REQ-019: SETUP: write_n = 1; when the counter expires, go to STROBE for STROBE_CYC cycles.
- REQ-020: STROBE: write_n = 0; when the counter expires, go to HOLD for HOLD_CYC cycles.
- REQ-021: On entry to HOLD, write_n = 1 and byte_done pulses for exactly one cycle.
- REQ-022: HOLD exit with FIFO non-empty: pop, load the next entry, and go directly to SETUP, with no IDLE cycle in between.
- REQ-023: HOLD exit with FIFO empty: go to IDLE, drive port_out = 8'hFF and rsel_out = 1.
- REQ-024: Latency: a beat accepted at edge t into an empty FIFO with the FSM in IDLE appears on port_out at edge t+1.
- REQ-025: For that beat, write_n falls at edge t+1+SETUP_CYC, rises at t+1+SETUP_CYC+STROBE_CYC, and the next byte loads at t+1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
- REQ-026: Back-to-back bytes occupy exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles each (8 cycles with defaults).
- REQ-027: port_out and rsel_out shall not change while write_n is low or during HOLD.
- REQ-028: Push and pop in the same cycle leave fifo_count unchanged; the FIFO order is strictly first-in, first-out.
- REQ-029: When full, in_ready = 0 and no beat is accepted; a pop that cycle raises in_ready on the next cycle, not combinationally.
- REQ-030: All outputs are registered, except in_ready, which is decoded from the registered fifo_count.
- REQ-031: An empty FIFO is never popped; IDLE persists with idle bus values.

Reset
- REQ-032: While Reset is high at a rising edge: FSM → IDLE, FIFO cleared, fifo_count = 0, port_out = 8'hFF, rsel_out = 1, write_n = 1, busy = 0, byte_done = 0.
- REQ-033: Reset asserted mid-transfer (including during STROBE) forces write_n = 1 on the next edge; the interrupted byte is discarded with no byte_done pulse.
- REQ-034: in_ready = 0 while Reset is high.
- REQ-035: The first beat can be accepted on the first edge after Reset falls.

Verification
- REQ-036: Single beat: Reset released, push {rsel=1, 8'h12} at edge 10 → port_out = 8'h12 and rsel_out = 1 at edge 11; write_n low for edges 13–16; byte_done at edge 17; bus back to 8'hFF/1 at edge 19.
- REQ-037: Burst: push 4 beats back-to-back (8'h01 rsel=1, then 8'hA0, 8'hA1, 8'hA2 with rsel=0) → fifo_count reaches 3; in_ready stays high; strobes spaced exactly 8 cycles apart; bytes appear in order; busy never drops between bytes.
- REQ-038: Full: hold in_valid high with 6 distinct bytes → in_ready drops when fifo_count = 4; no beat is lost or duplicated; all 6 bytes are transmitted in order.
- REQ-039: Reset mid-strobe: assert Reset in the 2nd STROBE cycle of byte 8'h55 with 2 beats queued → next edge write_n = 1, port_out = 8'hFF, fifo_count = 0; no byte_done; nothing further is transmitted.
- REQ-040: Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1: 3-beat burst → 3-cycle byte period; write_n low for exactly 1 cycle per byte.
- REQ-041: Simultaneous push/pop: with fifo_count = 2, push a beat in the cycle HOLD exits → fifo_count stays 2 and ordering is preserved.
